// File: rtl/pixel_arbiter_if.sv
// Pixel arbiter bus: draw requests and block descriptors in, grant/completion pulses, status
// and the registered VGA adapter write port out.
//   master: requester side (drives clr, req and block descriptors)
//   slave : arbiter side (drives ack, done, x, y, colour, plot, busy, init_done)
interface pixel_arbiter_if;
  logic       clr;
  logic [2:0] req;        // [0] tail erase, [1] head draw, [2] food draw
  logic [7:0] tail_x;
  logic [6:0] tail_y;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [2:0] head_col;
  logic [7:0] food_x;
  logic [6:0] food_y;
  logic [2:0] food_col;
  logic [2:0] ack;
  logic [2:0] done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       init_done;

  modport master (
    output clr, req, tail_x, tail_y, head_x, head_y, head_col, food_x, food_y, food_col,
    input  ack, done, x, y, colour, plot, busy, init_done
  );

  modport slave (
    input  clr, req, tail_x, tail_y, head_x, head_y, head_col, food_x, food_y, food_col,
    output ack, done, x, y, colour, plot, busy, init_done
  );
endinterface

// File: rtl/pixel_arbiter.sv
// Pixel arbiter: shares one VGA adapter write port between a full-screen clear and three
// 4x4 block requesters (tail erase, head draw, food draw).
// Ports:
//   clk     : system clock, all state on rising edge
//   resetn  : asynchronous active-low reset, forces a fresh full-screen clear
//   bus     : pixel_arbiter_if.slave (requests/blocks in; ack, done, x, y, colour, plot,
//             busy, init_done out -- all outputs registered except busy, decoded from state)
// RR_MODE: 0 = fixed priority req[0] > req[1] > req[2], 1 = round-robin.
module pixel_arbiter #(
  parameter int unsigned RR_MODE = 0
) (
  input logic             clk,
  input logic             resetn,
  pixel_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StClear, StIdle, StDraw} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cx_q, cx_d;        // clear raster x
  logic [6:0]  cy_q, cy_d;        // clear raster y, 120 marks the walk finished
  logic [3:0]  p_q, p_d;          // block pixel counter
  logic        fin_q, fin_d;      // pixel 15 has been presented
  logic [2:0]  gnt_q, gnt_d;      // current grant, one-hot
  logic [7:0]  bx_q, bx_d;
  logic [6:0]  by_q, by_d;
  logic [2:0]  bcol_q, bcol_d;
  logic [1:0]  rr_q, rr_d;        // index of last grant
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  done_q, done_d;
  logic        init_q, init_d;

  logic [2:0]  pick;
  logic [8:0]  sx;
  logic [7:0]  sy;
  logic        pix_ok;
  logic        clear_end;
  logic        decide;

  // Grant selection.
  always_comb begin
    pick = 3'b000;
    if (RR_MODE == 0) begin
      if (bus.req[0])      pick = 3'b001;
      else if (bus.req[1]) pick = 3'b010;
      else if (bus.req[2]) pick = 3'b100;
    end else begin
      unique case (rr_q)
        2'd0: begin
          if (bus.req[1])      pick = 3'b010;
          else if (bus.req[2]) pick = 3'b100;
          else if (bus.req[0]) pick = 3'b001;
        end
        2'd1: begin
          if (bus.req[2])      pick = 3'b100;
          else if (bus.req[0]) pick = 3'b001;
          else if (bus.req[1]) pick = 3'b010;
        end
        default: begin
          if (bus.req[0])      pick = 3'b001;
          else if (bus.req[1]) pick = 3'b010;
          else if (bus.req[2]) pick = 3'b100;
        end
      endcase
    end
  end

  // Wide sums so that 8/7-bit overflow lands outside the visible area and is suppressed.
  assign sx        = {1'b0, bx_q} + {7'd0, p_q[1:0]};
  assign sy        = {1'b0, by_q} + {6'd0, p_q[3:2]};
  assign pix_ok    = (sx <= 9'd159) && (sy <= 8'd119);
  assign clear_end = (cy_q == 7'd120);

  // The cycle after the last clear pixel or the last block pixel behaves as IDLE, so a
  // pending request can be granted on the very edge that leaves CLEAR or DRAW.
  assign decide = (state_q == StIdle) ||
                  ((state_q == StClear) && clear_end) ||
                  ((state_q == StDraw) && fin_q);

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    p_d     = p_q;
    fin_d   = fin_q;
    gnt_d   = gnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bcol_d  = bcol_q;
    rr_d    = rr_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    ack_d   = 3'b000;
    done_d  = 3'b000;
    init_d  = init_q;

    unique case (state_q)
      StClear: begin
        if (!clear_end) begin
          x_d    = cx_q;
          y_d    = cy_q;
          col_d  = 3'b000;
          plot_d = 1'b1;
          if (cx_q == 8'd159) begin
            cx_d = 8'd0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end else begin
          init_d = 1'b1;
        end
      end
      StDraw: begin
        if (!fin_q) begin
          x_d    = sx[7:0];
          y_d    = sy[6:0];
          col_d  = bcol_q;
          plot_d = pix_ok;
          p_d    = p_q + 4'd1;
          if (p_q == 4'd15) begin
            done_d = gnt_q;
            fin_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (decide) begin
      state_d = StIdle;
      if (bus.clr) begin
        state_d = StClear;
        cx_d    = 8'd0;
        cy_d    = 7'd0;
      end else if (pick != 3'b000) begin
        state_d = StDraw;
        ack_d   = pick;
        gnt_d   = pick;
        p_d     = 4'd0;
        fin_d   = 1'b0;
        if (pick[0]) begin
          bx_d   = bus.tail_x;
          by_d   = bus.tail_y;
          bcol_d = 3'b000;
          rr_d   = 2'd0;
        end else if (pick[1]) begin
          bx_d   = bus.head_x;
          by_d   = bus.head_y;
          bcol_d = bus.head_col;
          rr_d   = 2'd1;
        end else begin
          bx_d   = bus.food_x;
          by_d   = bus.food_y;
          bcol_d = bus.food_col;
          rr_d   = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StClear;
      cx_q    <= 8'd0;
      cy_q    <= 7'd0;
      p_q     <= 4'd0;
      fin_q   <= 1'b0;
      gnt_q   <= 3'b000;
      bx_q    <= 8'd0;
      by_q    <= 7'd0;
      bcol_q  <= 3'b000;
      rr_q    <= 2'd2;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'b000;
      plot_q  <= 1'b0;
      ack_q   <= 3'b000;
      done_q  <= 3'b000;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      p_q     <= p_d;
      fin_q   <= fin_d;
      gnt_q   <= gnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      bcol_q  <= bcol_d;
      rr_q    <= rr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      init_q  <= init_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = col_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.init_done = init_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Directed bench for pixel_arbiter: one fixed-priority and one round-robin instance share
// clock and reset; outputs are sampled 1 ns after each rising edge.
module tb_pixel_arbiter;
  logic clk;
  logic resetn;
  int   total;
  int   bad;
  int   npl;

  pixel_arbiter_if f_if ();
  pixel_arbiter_if r_if ();

  pixel_arbiter #(.RR_MODE(0)) u_fix (.clk(clk), .resetn(resetn), .bus(f_if.slave));
  pixel_arbiter #(.RR_MODE(1)) u_rr  (.clk(clk), .resetn(resetn), .bus(r_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 19200 raster pixels of the fixed instance, starting with the next edge.
  task automatic run_clear(input string tag);
    int ex;
    int ey;
    for (int i = 0; i < 19200; i++) begin
      tick();
      ex = i % 160;
      ey = i / 160;
      check(tag, 32'({f_if.plot, f_if.colour, f_if.y, f_if.x}),
            32'({1'b1, 3'b000, ey[6:0], ex[7:0]}));
    end
  endtask

  // 16 block pixels of the fixed instance after its grant edge.
  task automatic f_block(input string tag, input int x0, input int y0, input int col,
                         input logic [2:0] who, output int plotted);
    int   ex;
    int   ey;
    logic ok;
    plotted = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      ex = x0 + n % 4;
      ey = y0 + n / 4;
      ok = (ex <= 159) && (ey <= 119);
      check({tag, "_plot"}, 32'(f_if.plot), 32'(ok));
      if (ok) begin
        plotted++;
        check({tag, "_pix"}, 32'({f_if.colour, f_if.y, f_if.x}),
              32'({col[2:0], ey[6:0], ex[7:0]}));
      end
      check({tag, "_done"}, 32'(f_if.done), (n == 15) ? 32'(who) : 32'h0);
      check({tag, "_ack"}, 32'(f_if.ack), 32'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    f_if.clr = 1'b0; f_if.req = 3'b000;
    f_if.tail_x = 8'd10; f_if.tail_y = 7'd20;
    f_if.head_x = 8'd30; f_if.head_y = 7'd40; f_if.head_col = 3'd5;
    f_if.food_x = 8'd50; f_if.food_y = 7'd60; f_if.food_col = 3'd6;
    r_if.clr = 1'b0; r_if.req = 3'b000;
    r_if.tail_x = 8'd0; r_if.tail_y = 7'd0;
    r_if.head_x = 8'd4; r_if.head_y = 7'd4; r_if.head_col = 3'd1;
    r_if.food_x = 8'd8; r_if.food_y = 7'd8; r_if.food_col = 3'd2;

    // Reset state: x,y,colour,plot,ack,done = 0, busy = 1, init_done = 0.
    #12;
    check("rst_f", 32'({f_if.x, f_if.y, f_if.colour, f_if.plot, f_if.ack, f_if.done,
                        f_if.busy, f_if.init_done}), 32'h2);
    check("rst_r", 32'({r_if.x, r_if.y, r_if.plot, r_if.busy, r_if.init_done}), 32'h2);
    tick();
    resetn = 1'b1;

    // Power-up clear.
    run_clear("clear1");
    check("clear1_r_last", 32'({r_if.plot, r_if.y, r_if.x}), 32'({1'b1, 7'd119, 8'd159}));
    check("clear1_busy_last", 32'(f_if.busy), 32'h1);
    check("clear1_init_early", 32'(f_if.init_done), 32'h0);
    tick();
    check("clear1_end_f", 32'({f_if.plot, f_if.busy, f_if.init_done}), 32'h1);
    check("clear1_end_r", 32'({r_if.plot, r_if.busy, r_if.init_done}), 32'h1);

    // Fixed priority with all requests held; round-robin with 011 held alongside.
    f_if.req = 3'b111;
    r_if.req = 3'b011;
    for (int g = 0; g < 3; g++) begin
      tick();
      check("fix_ack", 32'(f_if.ack), 32'(1) << g);
      check("fix_busy", 32'(f_if.busy), 32'h1);
      check("rr_ack", 32'(r_if.ack), (g % 2 == 1) ? 32'h2 : 32'h1);
      f_if.req[g] = 1'b0;
      if (g == 0) f_block("tail", 10, 20, 0, 3'b001, npl);
      if (g == 1) begin
        f_if.head_x = 8'd99;   // latched at grant, must not affect this block
        f_block("head", 30, 40, 5, 3'b010, npl);
      end
      if (g == 2) f_block("food", 50, 60, 6, 3'b100, npl);
    end
    tick();
    check("fix_idle", 32'({f_if.ack, f_if.plot, f_if.busy}), 32'h0);
    check("rr_ack4", 32'(r_if.ack), 32'h2);
    r_if.req = 3'b000;

    // Block at the bottom-right corner: only 4 pixels visible.
    f_if.head_x = 8'd158; f_if.head_y = 7'd118; f_if.head_col = 3'd1;
    f_if.req = 3'b010;
    tick();
    check("edge_ack", 32'(f_if.ack), 32'h2);
    f_if.req = 3'b000;
    f_block("edge", 158, 118, 1, 3'b010, npl);
    check("edge_count", 32'(npl), 32'd4);
    tick();

    // 8-bit x overflow (255+1 wraps to 0) must still be suppressed.
    f_if.food_x = 8'd255; f_if.food_y = 7'd5; f_if.food_col = 3'd7;
    f_if.req = 3'b100;
    tick();
    check("ovf_ack", 32'(f_if.ack), 32'h4);
    f_if.req = 3'b000;
    f_block("ovf", 255, 5, 7, 3'b100, npl);
    check("ovf_count", 32'(npl), 32'd0);
    tick();

    // Reset asserted while pixel 7 of a tail erase is on the port.
    f_if.tail_x = 8'd0; f_if.tail_y = 7'd0;
    f_if.req = 3'b001;
    tick();
    check("mid_ack", 32'(f_if.ack), 32'h1);
    f_if.req = 3'b000;
    for (int n = 0; n < 8; n++) tick();
    check("mid_pix7", 32'({f_if.plot, f_if.y, f_if.x}), 32'({1'b1, 7'd1, 8'd3}));
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_async", 32'({f_if.x, f_if.y, f_if.colour, f_if.plot, f_if.ack, f_if.done,
                                f_if.busy, f_if.init_done}), 32'h2);
    for (int n = 0; n < 10; n++) begin
      tick();
      check("mid_rst_hold", 32'({f_if.x, f_if.y, f_if.colour, f_if.plot, f_if.ack, f_if.done,
                                 f_if.busy, f_if.init_done}), 32'h2);
    end
    resetn = 1'b1;
    r_if.req = 3'b110;   // round-robin pointer back at 2: head must win over food
    run_clear("clear2");
    check("clear2_r_ack", 32'(r_if.ack), 32'h0);
    tick();
    check("clear2_end_f", 32'({f_if.plot, f_if.busy, f_if.init_done}), 32'h1);
    check("rr_ptr_rst", 32'(r_if.ack), 32'h2);
    r_if.req = 3'b000;

    // clr and req together in IDLE: clear first, then the pending grant.
    f_if.head_x = 8'd5; f_if.head_y = 7'd6; f_if.head_col = 3'd2;
    f_if.clr = 1'b1;
    f_if.req = 3'b010;
    tick();
    check("clr_win", 32'({f_if.ack, f_if.plot, f_if.busy, f_if.init_done}), 32'h3);
    f_if.clr = 1'b0;
    run_clear("clear3");
    tick();
    check("clr_then_ack", 32'(f_if.ack), 32'h2);
    f_if.req = 3'b000;
    f_block("post_clr", 5, 6, 2, 3'b010, npl);
    tick();
    check("final_idle", 32'({f_if.busy, f_if.init_done}), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
